// File: rtl/prog_loader.sv
// Load-and-launch sequencer: streams instruction words into instruction memory
// over a valid/ready handshake, then raises go and waits for the CPU to finish.
module prog_loader #(
   parameter int unsigned INSTR_LEN = 20,
   parameter int unsigned ADDR      = 5,
   parameter int unsigned PROG_LEN  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [INSTR_LEN-1:0] in_data,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic [ADDR-1:0]      wr_addr,
   output logic [INSTR_LEN-1:0] wr_data,
   output logic                 go,
   input  logic                 cpu_done,
   output logic                 busy,
   output logic [ADDR:0]        loaded_count,
   output logic                 overflow
);

   localparam int unsigned CNT_W = ADDR + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_LAUNCH = 3'd2,
      S_RUN    = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR-1:0]        wr_addr_q, wr_addr_d;
   logic [INSTR_LEN-1:0]   wr_data_q, wr_data_d;
   logic                   overflow_q, overflow_d;
   logic                   in_ready_q, go_q, busy_q;
   logic                   accept;

   // The word count doubles as the write pointer; it never wraps inside a session.
   assign accept = in_valid & in_ready_q;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      overflow_d = overflow_q;
      case (state_q)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_d    = S_LOAD;
               count_d    = '0;
               overflow_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = count_q[ADDR-1:0];
               wr_data_d = in_data;
               count_d   = count_q + CNT_W'(1);
               if (in_last) begin
                  state_d = S_LAUNCH;
               end else if (count_q == CNT_W'(PROG_LEN - 1)) begin
                  state_d    = S_ERR;
                  overflow_d = 1'b1;
               end
            end
         end
         S_LAUNCH: state_d = S_RUN;
         S_RUN: begin
            if (cpu_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         overflow_q <= 1'b0;
         in_ready_q <= 1'b0;
         go_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         overflow_q <= overflow_d;
         in_ready_q <= (state_d == S_LOAD);
         go_q       <= (state_d == S_RUN);
         busy_q     <= (state_d == S_LOAD) || (state_d == S_LAUNCH) || (state_d == S_RUN);
      end
   end

   assign in_ready     = in_ready_q;
   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign go           = go_q;
   assign busy         = busy_q;
   assign loaded_count = count_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table-driven sessions, hand-written
// timing/reset sequences, and randomized sessions against a write-list model.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, in_valid, in_last, cpu_done;
   logic [19:0] in_data;
   logic        in_ready, wr_en, go, busy, overflow;
   logic [4:0]  wr_addr;
   logic [19:0] wr_data;
   logic [5:0]  loaded_count;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [4:0]  a;
      logic [19:0] d;
   } wr_t;

   typedef struct {
      int         n;
      bit         last;
      int         gap;
      logic [5:0] exp_cnt;
      bit         exp_ovf;
      bit         exp_go;
   } vec_t;

   wr_t         wq[$];
   logic [19:0] prog[$];

   prog_loader dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .go(go),
      .cpu_done(cpu_done), .busy(busy), .loaded_count(loaded_count),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Capture every memory write away from the active edge.
   always @(negedge clk) begin
      if (!reset && wr_en) wq.push_back('{a: wr_addr, d: wr_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
      chk({tag, "_wr_en"},    32'(wr_en), 0);
      chk({tag, "_go"},       32'(go), 0);
      chk({tag, "_busy"},     32'(busy), 0);
      chk({tag, "_overflow"}, 32'(overflow), 0);
      chk({tag, "_wr_addr"},  32'(wr_addr), 0);
      chk({tag, "_wr_data"},  32'(wr_data), 0);
      chk({tag, "_count"},    32'(loaded_count), 0);
   endtask

   // One full load session; the model is simply the ordered list of words sent.
   task automatic session(input int n, input bit last, input int gap,
                          input logic [5:0] exp_cnt, input bit exp_ovf, input bit exp_go);
      logic [19:0] w;
      int base;
      prog.delete();
      wq.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", 32'(busy), 1);
      chk("start_clears_ovf", 32'(overflow), 0);
      chk("start_clears_cnt", 32'(loaded_count), 0);
      chk("start_ready", 32'(in_ready), 1);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(0, 99) < 32'(gap)) begin
            in_valid = 1'b0;
            in_data  = 20'($urandom);
            tick();
         end
         w = 20'($urandom);
         prog.push_back(w);
         in_valid = 1'b1;
         in_data  = w;
         in_last  = last && (i == n - 1);
         chk("ready_in_load", 32'(in_ready), 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      tick();
      chk("n_writes", 32'(wq.size()), 32'(n));
      for (int i = 0; i < n && i < wq.size(); i++) begin
         chk("wr_addr_seq", 32'(wq[i].a), 32'(i));
         chk("wr_data_seq", 32'(wq[i].d), 32'(prog[i]));
      end
      chk("end_cnt", 32'(loaded_count), 32'(exp_cnt));
      chk("end_ovf", 32'(overflow), 32'(exp_ovf));
      chk("end_go", 32'(go), 32'(exp_go));
      chk("end_ready", 32'(in_ready), 0);
      chk("end_busy", 32'(busy), 32'(exp_go));
      base = wq.size();
      repeat ($urandom_range(1, 5)) begin
         in_valid = 1'($urandom);
         in_last  = 1'($urandom);
         in_data  = 20'($urandom);
         start    = exp_go ? 1'($urandom) : 1'b0;
         tick();
         chk("hold_go", 32'(go), 32'(exp_go));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
      tick();
      chk("no_extra_writes", 32'(wq.size()), 32'(base));
      if (exp_go) begin
         cpu_done = 1'b1;
         tick();
         cpu_done = 1'b0;
         chk("done_go_low", 32'(go), 0);
         chk("done_busy_low", 32'(busy), 0);
         chk("done_cnt_held", 32'(loaded_count), 32'(exp_cnt));
      end
   endtask

   initial begin
      vec_t        tbl[7];
      logic [19:0] w3[3];
      bit          vpat[5];
      int          k, n;
      bit          lst;

      tbl[0] = '{n: 3,  last: 1'b1, gap: 0,  exp_cnt: 6'd3,  exp_ovf: 1'b0, exp_go: 1'b1};
      tbl[1] = '{n: 3,  last: 1'b1, gap: 50, exp_cnt: 6'd3,  exp_ovf: 1'b0, exp_go: 1'b1};
      tbl[2] = '{n: 32, last: 1'b0, gap: 0,  exp_cnt: 6'd32, exp_ovf: 1'b1, exp_go: 1'b0};
      tbl[3] = '{n: 1,  last: 1'b1, gap: 0,  exp_cnt: 6'd1,  exp_ovf: 1'b0, exp_go: 1'b1};
      tbl[4] = '{n: 32, last: 1'b1, gap: 0,  exp_cnt: 6'd32, exp_ovf: 1'b0, exp_go: 1'b1};
      tbl[5] = '{n: 31, last: 1'b1, gap: 20, exp_cnt: 6'd31, exp_ovf: 1'b0, exp_go: 1'b1};
      tbl[6] = '{n: 32, last: 1'b0, gap: 40, exp_cnt: 6'd32, exp_ovf: 1'b1, exp_go: 1'b0};
      w3[0] = 20'h00011;
      w3[1] = 20'h00022;
      w3[2] = 20'h00033;
      vpat[0] = 1'b1; vpat[1] = 1'b0; vpat[2] = 1'b0; vpat[3] = 1'b1; vpat[4] = 1'b1;

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      cpu_done = 1'b0; in_data = '0;
      #12;
      chk_reset_values("rst");
      reset = 1'b0;
      tick();
      chk_reset_values("idle");

      // Exact timing of a 3-word stream, then launch and a long run.
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = w3[i];
         in_last = (i == 2);
         tick();
         chk("t1_wr_en", 32'(wr_en), 1);
         chk("t1_wr_addr", 32'(wr_addr), 32'(i));
         chk("t1_wr_data", 32'(wr_data), 32'(w3[i]));
         chk("t1_go_low", 32'(go), 0);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      chk("t1_go_rise", 32'(go), 1);
      chk("t1_wr_en_off", 32'(wr_en), 0);
      chk("t1_cnt", 32'(loaded_count), 3);
      repeat (10) begin
         tick();
         chk("t2_go_held", 32'(go), 1);
      end
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      chk("t2_go_drop", 32'(go), 0);
      chk("t2_busy_drop", 32'(busy), 0);

      // Gapped stream: a write appears only after an accepted cycle.
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      for (int i = 0; i < 5; i++) begin
         in_valid = vpat[i];
         in_data  = 20'h0A000 + 20'(i);
         in_last  = vpat[i] && (k == 2);
         tick();
         chk("t3_wr_en", 32'(wr_en), 32'(vpat[i]));
         if (vpat[i]) begin
            chk("t3_wr_addr", 32'(wr_addr), 32'(k));
            chk("t3_wr_data", 32'(wr_data), 32'(20'h0A000 + 20'(i)));
            k++;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      chk("t3_go", 32'(go), 1);
      chk("t3_single_pulse", 32'(wr_en), 0);
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;

      // Start and in_valid together in IDLE: only the state change happens.
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 20'hBEEF1;
      in_last  = 1'b1;
      tick();
      start = 1'b0;
      chk("sv_no_write", 32'(wr_en), 0);
      chk("sv_cnt", 32'(loaded_count), 0);
      chk("sv_ready", 32'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("sv_write", 32'(wr_en), 1);
      chk("sv_addr", 32'(wr_addr), 0);
      tick();
      tick();
      chk("sv_go", 32'(go), 1);
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;

      for (int i = 0; i < 7; i++) begin
         session(tbl[i].n, tbl[i].last, tbl[i].gap, tbl[i].exp_cnt, tbl[i].exp_ovf, tbl[i].exp_go);
      end

      // Reset in the middle of a load abandons it asynchronously.
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data = 20'h00100 + 20'(i);
         tick();
      end
      in_data = 20'h00102;
      #2;
      reset = 1'b1;
      #1;
      chk_reset_values("midrst");
      in_valid = 1'b0;
      #1;
      reset = 1'b0;
      session(1, 1'b1, 0, 6'd1, 1'b0, 1'b1);

      // Randomized sessions checked against the sent-word list.
      for (int r = 0; r < 20; r++) begin
         lst = ($urandom_range(0, 3) != 0);
         n   = lst ? int'($urandom_range(1, 32)) : 32;
         session(n, lst, int'($urandom_range(0, 60)), 6'(n), !lst, lst);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
